// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller and its playfield.
package pong_pkg;

    localparam int SCORE_W       = 4;
    localparam int WIN_SCORE_DEF = 7;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

endpackage

// File: rtl/pong_frame_timer.sv
// Loadable frame down-counter; expire flags the tick that lands while the count is 1.
module pong_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Load has priority so a reload on the expiring tick is never lost.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    assign expire = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Match-level sequencer: serve/point delays, scoring, winner and ball hold for the playfield.
//   state | meaning
//   IDLE  | waiting for start after reset
//   SERVE | ball parked at centre for SERVE_FRAMES ticks
//   PLAY  | ball live, waiting for a miss
//   POINT | pause of POINT_FRAMES ticks after a point
//   OVER  | match decided, scores frozen until restart
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = 120,
    parameter int POINT_FRAMES = 60,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               miss_1,
    input  logic               miss_2,
    output logic               ball_hold,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               serve_dir,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic [2:0]         state_o
);

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_CNT = CNT_W'(POINT_FRAMES);

    state_e               state_q, state_d;
    logic                 start_q;
    logic [SCORE_W-1:0]   score_1_q, score_1_d;
    logic [SCORE_W-1:0]   score_2_q, score_2_d;
    logic                 serve_dir_q, serve_dir_d;
    winner_e              winner_q, winner_d;

    logic                 start_pulse;
    logic [SCORE_W-1:0]   score_1_inc;
    logic [SCORE_W-1:0]   score_2_inc;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_tick;
    logic                 tmr_expire;

    assign start_pulse = start & ~start_q;
    assign score_1_inc = score_1_q + 1'b1;
    assign score_2_inc = score_2_q + 1'b1;

    pong_frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            score_1_q   <= '0;
            score_2_q   <= '0;
            serve_dir_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            score_1_q   <= score_1_d;
            score_2_q   <= score_2_d;
            serve_dir_q <= serve_dir_d;
            winner_q    <= winner_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_1_d   = score_1_q;
        score_2_d   = score_2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        tmr_load    = 1'b0;
        tmr_val     = SERVE_CNT;
        tmr_tick    = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start_pulse) begin
                    score_1_d = '0;
                    score_2_d = '0;
                    winner_d  = WIN_NONE;
                    tmr_load  = 1'b1;
                    state_d   = SERVE;
                end
            end
            SERVE: begin
                tmr_tick = frame_tick;
                if (tmr_expire) begin
                    state_d = PLAY;
                end
            end
            // miss_1 outranks miss_2 when both arrive together.
            PLAY: begin
                if (miss_1) begin
                    score_1_d   = score_1_inc;
                    serve_dir_d = 1'b1;
                    if (score_1_inc == WIN_VAL) begin
                        winner_d = WIN_P1;
                        state_d  = OVER;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = POINT_CNT;
                        state_d  = POINT;
                    end
                end else if (miss_2) begin
                    score_2_d   = score_2_inc;
                    serve_dir_d = 1'b0;
                    if (score_2_inc == WIN_VAL) begin
                        winner_d = WIN_P2;
                        state_d  = OVER;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = POINT_CNT;
                        state_d  = POINT;
                    end
                end
            end
            POINT: begin
                tmr_tick = frame_tick;
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    state_d  = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ball_hold = (state_q != PLAY);
        game_over = (state_q == OVER);
        state_o   = state_q;
        score_1   = score_1_q;
        score_2   = score_2_q;
        serve_dir = serve_dir_q;
        winner    = winner_q;
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short delays: win at 3, serve 3 ticks, point 2 ticks.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int WIN = 3;
    localparam int SF  = 3;
    localparam int PF  = 2;
    localparam int CW  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic       miss_1 = 1'b0;
    logic       miss_2 = 1'b0;
    logic       ball_hold;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       serve_dir;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .frame_tick (frame_tick),
        .miss_1     (miss_1),
        .miss_2     (miss_2),
        .ball_hold  (ball_hold),
        .score_1    (score_1),
        .score_2    (score_2),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner),
        .state_o    (state_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'(IDLE));
        check({tag, "_hold"}, 32'(ball_hold), 32'd1);
        check({tag, "_s1"}, 32'(score_1), 32'd0);
        check({tag, "_s2"}, 32'(score_2), 32'd0);
        check({tag, "_dir"}, 32'(serve_dir), 32'd0);
        check({tag, "_over"}, 32'(game_over), 32'd0);
        check({tag, "_win"}, 32'(winner), 32'd0);
    endtask

    // Returns #1 after the posedge that sampled the n-th frame_tick.
    task automatic wait_ticks(input int n);
        int   k = 0;
        int   cyc = 0;
        logic t;
        while (k < n && cyc < n * 10 + 20) begin
            @(posedge clk);
            t = frame_tick;
            #1;
            cyc++;
            if (t) k++;
        end
        if (k != n) check("tick_budget", 32'(k), 32'(n));
    endtask

    // One-clock frame_tick every 10 clocks, changed on falling edges.
    initial begin
        forever begin
            repeat (9) @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_reset_vals("idle50");

        // Held start: one IDLE->SERVE, PLAY on the 3rd tick.
        start = 1'b1;
        @(posedge clk); #1;
        check("start_serve", 32'(state_o), 32'(SERVE));
        check("start_hold", 32'(ball_hold), 32'd1);
        wait_ticks(2);
        check("serve_t2", 32'(state_o), 32'(SERVE));
        check("serve_t2_hold", 32'(ball_hold), 32'd1);
        wait_ticks(1);
        check("play_t3", 32'(state_o), 32'(PLAY));
        check("play_t3_hold", 32'(ball_hold), 32'd0);
        repeat (12) @(negedge clk);
        check("start_held_play", 32'(state_o), 32'(PLAY));
        start = 1'b0;

        // miss_1 held 25 clocks counts once.
        miss_1 = 1'b1;
        fork
            begin
                repeat (25) @(negedge clk);
                miss_1 = 1'b0;
            end
        join_none
        @(posedge clk); #1;
        check("m1_score", 32'(score_1), 32'd1);
        check("m1_dir", 32'(serve_dir), 32'd1);
        check("m1_state", 32'(state_o), 32'(POINT));
        check("m1_hold", 32'(ball_hold), 32'd1);
        wait_ticks(2);
        check("point_to_serve", 32'(state_o), 32'(SERVE));
        check("m1_held_score", 32'(score_1), 32'd1);
        wait_ticks(3);
        check("serve_to_play", 32'(state_o), 32'(PLAY));
        check("m1_final_score", 32'(score_1), 32'd1);

        // Both misses together: miss_1 wins.
        @(negedge clk);
        miss_1 = 1'b1;
        miss_2 = 1'b1;
        @(posedge clk); #1;
        check("both_s1", 32'(score_1), 32'd2);
        check("both_s2", 32'(score_2), 32'd0);
        check("both_state", 32'(state_o), 32'(POINT));
        @(negedge clk);
        miss_1 = 1'b0;
        miss_2 = 1'b0;
        wait_ticks(5);
        check("both_replay", 32'(state_o), 32'(PLAY));

        // Asynchronous reset mid-PLAY, away from any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;

        // Player 2 wins 3-0.
        start = 1'b1;
        @(posedge clk); #1;
        check("m2_start", 32'(state_o), 32'(SERVE));
        @(negedge clk);
        start = 1'b0;
        wait_ticks(3);
        check("m2_play0", 32'(state_o), 32'(PLAY));
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            miss_2 = 1'b1;
            @(posedge clk); #1;
            check("m2_score", 32'(score_2), 32'(r));
            check("m2_dir", 32'(serve_dir), 32'd0);
            @(negedge clk);
            miss_2 = 1'b0;
            if (r < 3) begin
                check("m2_point", 32'(state_o), 32'(POINT));
                wait_ticks(5);
                check("m2_replay", 32'(state_o), 32'(PLAY));
            end
        end
        check("over_state", 32'(state_o), 32'(OVER));
        check("over_flag", 32'(game_over), 32'd1);
        check("over_winner", 32'(winner), 32'd2);
        check("over_hold", 32'(ball_hold), 32'd1);
        check("over_s1", 32'(score_1), 32'd0);

        @(negedge clk);
        miss_1 = 1'b1;
        miss_2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        miss_1 = 1'b0;
        miss_2 = 1'b0;
        check("frozen_s1", 32'(score_1), 32'd0);
        check("frozen_s2", 32'(score_2), 32'd3);
        check("frozen_win", 32'(winner), 32'd2);
        wait_ticks(1);
        check("frozen_state", 32'(state_o), 32'(OVER));

        // Restart on the same edge as a frame_tick: counter must load, not decrement.
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        check("restart_state", 32'(state_o), 32'(SERVE));
        check("restart_s2", 32'(score_2), 32'd0);
        check("restart_win", 32'(winner), 32'd0);
        check("restart_over", 32'(game_over), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_ticks(2);
        check("restart_t2", 32'(state_o), 32'(SERVE));
        wait_ticks(1);
        check("restart_t3", 32'(state_o), 32'(PLAY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
